// File: rtl/ls_moment_acc_if.sv
// Sample-in / results-out bundle for the least-squares moment accumulator.
// The slave modport is the accumulator; the master modport is whoever feeds and drains it.
interface ls_moment_acc_if #(
    parameter int XW   = 12,
    parameter int YW   = 12,
    parameter int DEG  = 2,
    parameter int ACCW = 56
);
    logic                         start;
    logic                         in_valid;
    logic                         in_ready;
    logic [XW-1:0]                x_in;
    logic [YW-1:0]                y_in;
    logic                         busy;
    logic                         out_valid;
    logic                         out_ready;
    logic [(2*DEG+1)*ACCW-1:0]    sx;
    logic [(DEG+1)*ACCW-1:0]      sxy;
    logic                         ovf;

    modport master (
        output start, in_valid, x_in, y_in, out_ready,
        input  in_ready, busy, out_valid, sx, sxy, ovf
    );

    modport slave (
        input  start, in_valid, x_in, y_in, out_ready,
        output in_ready, busy, out_valid, sx, sxy, ovf
    );
endinterface

// File: rtl/ls_moment_acc.sv
// Batch accumulator of power sums sum(x^k) and cross sums sum(y*x^k) for a degree-DEG
// polynomial least-squares fit, with a two-stage pipeline and a held result handshake.
module ls_moment_acc #(
    parameter int N    = 256,
    parameter int DEG  = 2,
    parameter int XW   = 12,
    parameter int YW   = 12,
    parameter int FRAC = 4,
    parameter int ACCW = 56
) (
    input  logic            clk,
    input  logic            rst,
    ls_moment_acc_if.slave  bus
);

    localparam int NSX  = 2 * DEG + 1;
    localparam int NSXY = DEG + 1;
    localparam int PW   = 2 * DEG * XW;     // exact width of x^(2*DEG)
    localparam int YPW  = YW + DEG * XW;    // exact width of y*x^DEG
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    // FRAC only documents where the binary points sit; nothing is rescaled here.
    if (FRAC > XW || FRAC > YW) begin : g_frac_wider_than_sample
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_in_ready;
    logic            w_busy;
    logic            w_out_valid;
    logic            w_clear;
    logic            w_accept;

    logic [CW-1:0]   r_cnt;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_s1_valid;
    logic            r_ovf;

    logic [PW-1:0]   w_pow  [0:NSX-1];
    logic [YPW-1:0]  w_ypow [0:NSXY-1];
    logic [NSX-1:0]  w_flag_sx;
    logic [NSXY-1:0] w_flag_sxy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_out_valid  = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_clear      = 1'b1;
                    w_state_next = S_ACC;
                end
            end
            S_ACC: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (bus.in_valid && r_cnt == CNT_LAST) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Stay until the final stage-1 sample has reached the accumulators.
                w_busy = 1'b1;
                if (!r_s1_valid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (bus.start) begin
                        w_clear      = 1'b1;
                        w_state_next = S_ACC;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_accept      = bus.in_valid & w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = w_out_valid;
    assign bus.ovf       = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_s1_valid <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_x <= bus.x_in;
                r_y <= bus.y_in;
            end
            if (w_clear) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
            end
            if (w_clear) begin
                r_ovf <= 1'b0;
            end else if (r_s1_valid && (|w_flag_sx || |w_flag_sxy)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign w_pow[0] = PW'(1);
    for (genvar gi = 1; gi < NSX; gi++) begin : g_pow
        assign w_pow[gi] = w_pow[gi-1] * PW'(r_x);
    end

    for (genvar gi = 0; gi < NSXY; gi++) begin : g_ypow
        assign w_ypow[gi] = YPW'(r_y) * YPW'(w_pow[gi]);
    end

    for (genvar gi = 0; gi < NSX; gi++) begin : g_sx
        logic [ACCW-1:0] w_term;
        logic            w_trunc;
        logic [ACCW:0]   w_sum;
        logic [ACCW-1:0] r_acc;

        if (PW > ACCW) begin : g_cut
            assign w_term  = w_pow[gi][ACCW-1:0];
            assign w_trunc = |w_pow[gi][PW-1:ACCW];
        end else begin : g_fit
            assign w_term  = ACCW'(w_pow[gi]);
            assign w_trunc = 1'b0;
        end

        assign w_sum         = {1'b0, r_acc} + {1'b0, w_term};
        assign w_flag_sx[gi] = w_trunc | w_sum[ACCW];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
            end else if (w_clear) begin
                r_acc <= '0;
            end else if (r_s1_valid) begin
                r_acc <= w_sum[ACCW-1:0];
            end
        end

        assign bus.sx[gi*ACCW +: ACCW] = r_acc;
    end

    for (genvar gi = 0; gi < NSXY; gi++) begin : g_sxy
        logic [ACCW-1:0] w_term;
        logic            w_trunc;
        logic [ACCW:0]   w_sum;
        logic [ACCW-1:0] r_acc;

        if (YPW > ACCW) begin : g_cut
            assign w_term  = w_ypow[gi][ACCW-1:0];
            assign w_trunc = |w_ypow[gi][YPW-1:ACCW];
        end else begin : g_fit
            assign w_term  = ACCW'(w_ypow[gi]);
            assign w_trunc = 1'b0;
        end

        assign w_sum          = {1'b0, r_acc} + {1'b0, w_term};
        assign w_flag_sxy[gi] = w_trunc | w_sum[ACCW];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
            end else if (w_clear) begin
                r_acc <= '0;
            end else if (r_s1_valid) begin
                r_acc <= w_sum[ACCW-1:0];
            end
        end

        assign bus.sxy[gi*ACCW +: ACCW] = r_acc;
    end

endmodule

// File: tb/tb_ls_moment_acc.sv
// Scoreboard bench for ls_moment_acc: directed batches plus random batches checked
// against a plain-arithmetic model of the power and cross sums.
module tb_ls_moment_acc;

    localparam int N    = 4;
    localparam int DEG  = 2;
    localparam int XW   = 12;
    localparam int YW   = 12;
    localparam int FRAC = 4;
    localparam int ACCW = 20;
    localparam int NSX  = 2 * DEG + 1;
    localparam int NSXY = DEG + 1;

    typedef struct packed {
        logic [NSX-1:0][ACCW-1:0]  sx;
        logic [NSXY-1:0][ACCW-1:0] sxy;
        logic                      ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    logic [XW-1:0] xs [N];
    logic [YW-1:0] ys [N];
    exp_t          exp_q [$];
    exp_t          e_basic;
    exp_t          e_ones;

    ls_moment_acc_if #(.XW(XW), .YW(YW), .DEG(DEG), .ACCW(ACCW)) bif ();

    ls_moment_acc #(
        .N(N), .DEG(DEG), .XW(XW), .YW(YW), .FRAC(FRAC), .ACCW(ACCW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference: sums of the ACCW-bit truncated terms; any truncated term or any
    // sum reaching 2^ACCW means some accumulator add carried out.
    function automatic exp_t model();
        exp_t        e;
        logic [63:0] lim;
        logic [63:0] p;
        logic [63:0] tot;
        e   = '0;
        lim = 64'd1 << ACCW;
        for (int k = 0; k < NSX; k++) begin
            tot = 0;
            for (int i = 0; i < N; i++) begin
                p = 1;
                for (int j = 0; j < k; j++) p = p * xs[i];
                if (p >= lim) e.ovf = 1'b1;
                tot = tot + (p % lim);
            end
            if (tot >= lim) e.ovf = 1'b1;
            e.sx[k] = ACCW'(tot % lim);
        end
        for (int k = 0; k < NSXY; k++) begin
            tot = 0;
            for (int i = 0; i < N; i++) begin
                p = 64'(ys[i]);
                for (int j = 0; j < k; j++) p = p * xs[i];
                if (p >= lim) e.ovf = 1'b1;
                tot = tot + (p % lim);
            end
            if (tot >= lim) e.ovf = 1'b1;
            e.sxy[k] = ACCW'(tot % lim);
        end
        return e;
    endfunction

    task automatic fill(input int xv, input int yv);
        for (int i = 0; i < N; i++) begin
            xs[i] = XW'(xv);
            ys[i] = YW'(yv);
        end
    endtask

    task automatic send_sample(input logic [XW-1:0] x, input logic [YW-1:0] y, input bit gaps);
        int ng;
        int t;
        ng = gaps ? int'($urandom_range(1, 2)) : 0;
        for (int g = 0; g < ng; g++) begin
            bif.in_valid = 1'b0;
            bif.start    = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("in_ready_during_gap", 64'(bif.in_ready), 64'd1);
        end
        bif.start    = 1'b0;
        bif.in_valid = 1'b1;
        bif.x_in     = x;
        bif.y_in     = y;
        t = 0;
        while (!bif.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("in_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    // Caller guarantees IDLE when b2b=0, DONE when b2b=1. Leaves the DUT in DONE.
    task automatic run_batch(input bit gaps, input bit b2b, input exp_t e);
        int lat;
        bif.start     = 1'b1;
        bif.out_ready = b2b;
        @(negedge clk);
        bif.start     = 1'b0;
        bif.out_ready = 1'b0;
        chk("busy_after_start", 64'(bif.busy), 64'd1);
        chk("out_valid_after_start", 64'(bif.out_valid), 64'd0);
        for (int i = 0; i < N; i++) send_sample(xs[i], ys[i], gaps);
        exp_q.push_back(e);
        lat = 0;
        while (!bif.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("result_latency", 64'(lat), 64'd2);
    endtask

    task automatic consume();
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        chk("out_valid_after_take", 64'(bif.out_valid), 64'd0);
        chk("busy_after_take", 64'(bif.busy), 64'd0);
    endtask

    // Monitor: compares each result set as it is presented.
    initial begin
        logic ov_q;
        exp_t e;
        ov_q = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.out_valid && !ov_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result got=out_valid exp=no_pending_batch");
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < NSX; k++)
                        chk($sformatf("sx[%0d]", k), 64'(bif.sx[k*ACCW +: ACCW]), 64'(e.sx[k]));
                    for (int k = 0; k < NSXY; k++)
                        chk($sformatf("sxy[%0d]", k), 64'(bif.sxy[k*ACCW +: ACCW]), 64'(e.sxy[k]));
                    chk("ovf", 64'(bif.ovf), 64'(e.ovf));
                    $display("TXN %0d sx0=%0d sx1=%0d sx4=%0d sxy0=%0d sxy2=%0d ovf=%0d", txn,
                             bif.sx[0 +: ACCW], bif.sx[ACCW +: ACCW], bif.sx[4*ACCW +: ACCW],
                             bif.sxy[0 +: ACCW], bif.sxy[2*ACCW +: ACCW], bif.ovf);
                    txn++;
                end
            end
            ov_q = bif.out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit in_done;
        bif.start     = 1'b0;
        bif.in_valid  = 1'b0;
        bif.x_in      = '0;
        bif.y_in      = '0;
        bif.out_ready = 1'b0;

        e_basic = '0;
        e_basic.sx[0]  = 4;     e_basic.sx[1] = 64;     e_basic.sx[2] = 1024;
        e_basic.sx[3]  = 16384; e_basic.sx[4] = 262144;
        e_basic.sxy[0] = 128;   e_basic.sxy[1] = 2048;  e_basic.sxy[2] = 32768;
        e_ones = '0;
        for (int k = 0; k < NSX; k++)  e_ones.sx[k]  = 4;
        for (int k = 0; k < NSXY; k++) e_ones.sxy[k] = 4;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(bif.in_ready), 64'd0);
        chk("reset_busy", 64'(bif.busy), 64'd0);
        chk("reset_out_valid", 64'(bif.out_valid), 64'd0);
        chk("reset_ovf", 64'(bif.ovf), 64'd0);
        chk("reset_sx4", 64'(bif.sx[4*ACCW +: ACCW]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sums, back to back samples
        fill(16, 32);
        run_batch(1'b0, 1'b0, e_basic);

        // Output hold with a stray start
        for (int c = 0; c < 10; c++) begin
            bif.out_ready = 1'b0;
            bif.start     = (c == 4);
            @(negedge clk);
            chk("hold_out_valid", 64'(bif.out_valid), 64'd1);
            chk("hold_sx4", 64'(bif.sx[4*ACCW +: ACCW]), 64'(e_basic.sx[4]));
            chk("hold_sxy2", 64'(bif.sxy[2*ACCW +: ACCW]), 64'(e_basic.sxy[2]));
            chk("hold_busy", 64'(bif.busy), 64'd0);
        end
        bif.start = 1'b0;
        consume();
        chk("idle_in_ready", 64'(bif.in_ready), 64'd0);

        // Input gaps
        run_batch(1'b1, 1'b0, e_basic);

        // Back-to-back batch from DONE
        fill(32, 16);
        run_batch(1'b0, 1'b1, model());
        consume();

        // Overflow, then a clean batch must clear the flag
        fill(4095, 4095);
        run_batch(1'b0, 1'b0, model());
        chk("ovf_flag_set", 64'(bif.ovf), 64'd1);
        fill(1, 1);
        run_batch(1'b0, 1'b1, e_ones);
        consume();

        // Asynchronous reset after two accepts
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        send_sample(12'd100, 12'd200, 1'b0);
        send_sample(12'd300, 12'd400, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", 64'(bif.in_ready), 64'd0);
        chk("abort_busy", 64'(bif.busy), 64'd0);
        chk("abort_out_valid", 64'(bif.out_valid), 64'd0);
        chk("abort_ovf", 64'(bif.ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill(16, 32);
        run_batch(1'b0, 1'b0, e_basic);
        in_done = 1'b1;

        // Random batches
        for (int b = 0; b < 10; b++) begin
            bit wide;
            bit b2b;
            wide = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                xs[i] = wide ? XW'($urandom_range(0, 4095)) : XW'($urandom_range(0, 31));
                ys[i] = YW'($urandom_range(0, 4095));
            end
            b2b = 1'($urandom_range(0, 1));
            if (in_done && !b2b) consume();
            run_batch(1'($urandom_range(0, 1)), b2b, model());
        end
        consume();

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ls_moment_acc.md
# ls_moment_acc

Parametrised least-squares moment accumulator for the option-pricing regression path. Over one batch of N samples it accumulates the power sums Σx^k for k = 0..2·DEG and the cross sums Σy·x^k for k = 0..DEG. These are the raw entries of XᵀX and XᵀY for a degree-DEG polynomial fit. It feeds the matrix-inverse stage and adds four things the fixed degree-1/degree-2 accumulators lacked:
- per-sample valid/ready flow control,
- a held result handshake,
- a sticky overflow flag,
- a configurable degree, width and batch length.

## Interface
Parameters:
- N, 256: samples per batch, ≥ 1.
- DEG, 2: polynomial degree, 1..3.
- XW, 12: width of x. Unsigned fixed point with FRAC fraction bits.
- YW, 12: width of y. Unsigned fixed point with FRAC fraction bits.
- FRAC, 4: fraction bits of x and y. Informational only; no rescaling is done.
- ACCW, 56: width of every accumulator.

Ports:
- clk, input, 1: clock. All logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a batch. Sampled in IDLE, or in DONE when out_ready is also high.
- in_valid, input, 1: x_in/y_in are valid.
- in_ready, output, 1: block accepts a sample this cycle.
- x_in, input, XW: sample abscissa.
- y_in, input, YW: sample ordinate.
- busy, output, 1: high in ACC and DRAIN.
- out_valid, output, 1: results are valid and held.
- out_ready, input, 1: consumer takes the results.
- sx, output, (2·DEG+1)·ACCW: Σx^k. Slice k is sx[k·ACCW +: ACCW].
- sxy, output, (DEG+1)·ACCW: Σy·x^k. Slice k is sxy[k·ACCW +: ACCW].
- ovf, output, 1: sticky; set if any term was truncated or any accumulator wrapped this batch.

## Operation
- States: IDLE, ACC, DRAIN, DONE.
- Reset: state = IDLE; all accumulators, the sample counter, the pipeline register, ovf, out_valid and busy go to 0; in_ready = 0.
- IDLE:
  - in_ready = 0.
  - start = 1 clears all accumulators, the counter and ovf, then moves to ACC.
- ACC:
  - in_ready = 1.
  - Accept = in_valid & in_ready.
  - Each accept loads (x_in, y_in) into the stage-1 register and increments the counter.
  - An accept while counter = N−1 moves to DRAIN.
  - in_valid low leaves the state unchanged (gaps allowed).
  - start is ignored.
- DRAIN:
  - in_ready = 0.
  - The last registered sample is accumulated, then the block moves to DONE.
  - start is ignored.
- DONE:
  - out_valid = 1; sx, sxy and ovf are held stable.
  - out_ready = 1 moves to IDLE.
  - out_ready = 1 together with start = 1 moves directly to ACC with the accumulators cleared (back-to-back batches).
  - start without out_ready is ignored.
- Arithmetic (stage 2, from the stage-1 register):
  - Powers p_k = x^k are computed at full precision. p_0 = 1.
  - Updates: sx[k] += p_k for k ≤ 2·DEG; sxy[k] += y·p_k for k ≤ DEG.
  - All arithmetic is unsigned and wraps modulo 2^ACCW.
  - A term wider than ACCW is truncated to its low ACCW bits; any nonzero discarded bit sets ovf.
  - A carry out of any accumulator add sets ovf.
- Result scaling: the raw binary point of sx[k] is k·FRAC and of sxy[k] is (k+1)·FRAC. Downstream realigns.
- Overflow-free sizing: ACCW ≥ 2·DEG·XW + clog2(N) and ACCW ≥ DEG·XW + YW + clog2(N). Smaller ACCW is legal; ovf then reports any overflow.

## Timing
- Pipeline:
  - Stage 1 registers the sample on accept.
  - Stage 2 updates the accumulators on the next edge.
  - At most one sample is accepted per cycle.
- Latency: the last accept is at edge T; the DRAIN update is at T+1; out_valid rises after edge T+2.
- out_valid falls the cycle after the edge at which out_ready was sampled high in DONE.
- With continuous in_valid, a batch takes N+2 cycles from the first accept to out_valid.
- Reset asserted at any point (mid-batch, DRAIN or DONE) aborts immediately to the reset values. Partial sums are discarded; no out_valid pulse.
- Result ports keep their last value in IDLE; they are only meaningful while out_valid = 1.

## Test plan
- Basic sums (N=4, DEG=2, defaults otherwise), 4 samples of x=16 (1.0), y=32 (2.0), back to back → sx = {4, 64, 1024, 16384, 262144}, sxy = {128, 2048, 32768}, ovf=0. out_valid rises 2 cycles after the 4th accept.
- Input gaps (N=4): same data with in_valid low on alternate cycles → identical results; in_ready stays 1 throughout ACC.
- Output hold (N=4): hold out_ready=0 for 10 cycles in DONE → out_valid and sums stay stable. out_ready=1 → IDLE next cycle, out_valid=0. start during the hold → ignored.
- Back-to-back (N=4): out_ready=1 with start=1 in DONE → ACC with zeroed sums. A second batch with x=32, y=16 gives sx1=128 and sxy0=64, with no leakage from batch 1.
- Overflow (ACCW=20, N=4): x=4095, y=4095 → ovf=1 at out_valid. A following batch with x=1, y=1 → ovf=0, sx={4,4,4,4,4}.
- Reset mid-batch (N=4): assert rst after 2 accepts → in_ready, busy, out_valid, ovf = 0 asynchronously. A subsequent full batch reproduces the first scenario exactly.
